// File: rtl/facq_sched_pkg.sv
// Shared types for the fast-acquisition PRN generator scheduler.
// Optional build macro: FACQ_SCHED_STAT_EN (per-channel dwell statistics).
package facq_sched_pkg;

    localparam int FACQ_PRNSIZE  = 14;
    localparam int FACQ_CNTRSIZE = 14;
    localparam int FACQ_OVLSIZE  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LOAD,
        S_WAIT,
        S_RUN,
        S_SAVE
    } sched_state_t;

    // One saved generator context: both LFSRs, chip counter, overlay counter.
    typedef struct packed {
        logic [FACQ_PRNSIZE-1:0]  sr1;
        logic [FACQ_PRNSIZE-1:0]  sr2;
        logic [FACQ_CNTRSIZE-1:0] prn;
        logic [FACQ_OVLSIZE-1:0]  ovl;
    } prn_ctx_t;

endpackage

// File: rtl/facq_sched_rr.sv
// Combinational round-robin picker: first set mask bit after ptr_i, wrapping.
// The pointer register lives in the parent.
module facq_sched_rr #(
    parameter int NCH = 4,
    localparam int IW = $clog2(NCH)
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [IW-1:0]  grant_o,
    output logic           any_o
);

    logic [IW-1:0] idx;

    // Scan ptr+1 .. ptr+NCH (the last step lands on ptr itself); NCH is a power of 2.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = ptr_i + IW'(i);
            if (!any_o && mask_i[idx]) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/facq_prn_sched.sv
// Time-multiplexes one PRN generator across NCH search channels: restores a
// channel context, runs the generator for a dwell, saves the context back.
// Optional build macro: FACQ_SCHED_STAT_EN adds per-channel 16-bit saturating
// counts of completed (saved) dwells; without it stat_cnt reads 0.
module facq_prn_sched
    import facq_sched_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int PRNSIZE  = FACQ_PRNSIZE,
    parameter int CNTRSIZE = FACQ_CNTRSIZE,
    parameter int DWELL_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_en,
    input  logic [NCH-1:0]          ch_en,
    input  logic [DWELL_W-1:0]      dwell_len,
    input  logic                    ctx_we,
    input  logic [$clog2(NCH)-1:0]  ctx_ch,
    input  logic [PRNSIZE-1:0]      ctx_sr1,
    input  logic [PRNSIZE-1:0]      ctx_sr2,
    input  logic [CNTRSIZE-1:0]     ctx_prn,
    input  logic [4:0]              ctx_ovl,
    output logic                    gen_do_init,
    output logic [PRNSIZE-1:0]      gen_code_state1,
    output logic [PRNSIZE-1:0]      gen_code_state2,
    output logic [CNTRSIZE-1:0]     gen_prn_init,
    output logic [4:0]              gen_ovl_init,
    output logic                    gen_we,
    input  logic [PRNSIZE-1:0]      gen_sr1,
    input  logic [PRNSIZE-1:0]      gen_sr2,
    input  logic [CNTRSIZE-1:0]     gen_prn_counter,
    input  logic [4:0]              gen_ovl_cntr,
    output logic                    slot_valid,
    output logic [$clog2(NCH)-1:0]  slot_ch,
    input  logic                    slot_ready,
    output logic                    slot_done,
    output logic                    busy,
    input  logic [$clog2(NCH)-1:0]  stat_ch,
    output logic [15:0]             stat_cnt
);

    localparam int IW = $clog2(NCH);

    sched_state_t       state_q, state_d;
    logic [IW-1:0]      cur_q, ptr_q;
    logic               first_q;       // no slot saved since reset: search starts at channel 0
    logic               abandon_q;     // CPU rewrote the current channel; skip the save
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_last_q;
    prn_ctx_t           ctx_q [NCH];
    prn_ctx_t           load_q;
    logic               do_init_q;

    logic [IW-1:0]      grant, ptr_eff;
    logic               any;
    logic               start_slot, accept, save_wr, cpu_hit_cur;
    prn_ctx_t           cpu_ctx, live_ctx;

    assign cpu_ctx  = '{sr1: ctx_sr1, sr2: ctx_sr2, prn: ctx_prn, ovl: ctx_ovl};
    assign live_ctx = '{sr1: gen_sr1, sr2: gen_sr2, prn: gen_prn_counter, ovl: gen_ovl_cntr};

    assign ptr_eff = first_q ? IW'(NCH - 1) : ptr_q;

    facq_sched_rr #(.NCH(NCH)) u_rr (
        .mask_i  (ch_en),
        .ptr_i   (ptr_eff),
        .grant_o (grant),
        .any_o   (any)
    );

    assign cpu_hit_cur = ctx_we && (ctx_ch == cur_q) &&
                         ((state_q == S_WAIT) || (state_q == S_RUN));
    // A same-cycle CPU write to the saving channel takes precedence.
    assign save_wr     = (state_q == S_SAVE) && !abandon_q &&
                         !(ctx_we && (ctx_ch == cur_q));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d    = state_q;
        start_slot = 1'b0;
        accept     = 1'b0;
        gen_we     = 1'b0;
        slot_valid = 1'b0;
        slot_done  = 1'b0;
        case (state_q)
            S_IDLE:   if (run_en) state_d = S_SELECT;
            S_SELECT: begin
                if (run_en && any) begin
                    start_slot = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_LOAD:   state_d = S_WAIT;
            S_WAIT: begin
                slot_valid = 1'b1;
                if (slot_ready) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else if (!run_en) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                gen_we = 1'b1;
                if (dwell_cnt_q == dwell_last_q) begin
                    slot_done = 1'b1;
                    state_d   = S_SAVE;
                end
            end
            S_SAVE:   state_d = S_SELECT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Slot bookkeeping: current channel, restored context, dwell counter, flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q        <= '0;
            ptr_q        <= '0;
            first_q      <= 1'b1;
            abandon_q    <= 1'b0;
            dwell_cnt_q  <= '0;
            dwell_last_q <= '0;
            load_q       <= '0;
            do_init_q    <= 1'b0;
        end else begin
            do_init_q <= start_slot;
            if (start_slot) begin
                cur_q  <= grant;
                load_q <= (ctx_we && (ctx_ch == grant)) ? cpu_ctx : ctx_q[grant];
            end
            if (accept) begin
                dwell_cnt_q  <= '0;
                dwell_last_q <= (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
            end else if (state_q == S_RUN) begin
                dwell_cnt_q  <= dwell_cnt_q + DWELL_W'(1);
            end
            if (state_q == S_SELECT) abandon_q <= 1'b0;
            else if (cpu_hit_cur)    abandon_q <= 1'b1;
            if (state_q == S_SAVE) begin
                ptr_q   <= cur_q;
                first_q <= 1'b0;
            end
        end
    end

    // Context storage: CPU writes any time, SAVE writes back the live generator.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the context array is flops, so it is cleared by reset like any other state.
        if (reset) begin
            for (int i = 0; i < NCH; i++) ctx_q[i] <= '0;
        end else begin
            if (ctx_we)  ctx_q[ctx_ch] <= cpu_ctx;
            if (save_wr) ctx_q[cur_q]  <= live_ctx;
        end
    end

    assign gen_do_init     = do_init_q;
    assign gen_code_state1 = load_q.sr1;
    assign gen_code_state2 = load_q.sr2;
    assign gen_prn_init    = load_q.prn;
    assign gen_ovl_init    = load_q.ovl;
    assign slot_ch         = cur_q;
    assign busy            = (state_q != S_IDLE);

`ifdef FACQ_SCHED_STAT_EN
    logic [15:0] stat_q [NCH];

    // Saturating count of dwells whose context was saved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) stat_q[i] <= '0;
        end else if (save_wr && (stat_q[cur_q] != 16'hFFFF)) begin
            stat_q[cur_q] <= stat_q[cur_q] + 16'd1;
        end
    end

    assign stat_cnt = stat_q[stat_ch];
`else
    logic unused_stat_ch;
    assign unused_stat_ch = ^stat_ch;
    assign stat_cnt       = '0;
`endif

endmodule

// File: tb/tb_facq_prn_sched.sv
// Self-checking bench for facq_prn_sched with an emulated PRN generator and a
// per-channel reference model of code phase, round-robin order and statistics.
module tb_facq_prn_sched;

    typedef struct packed {
        logic [13:0] sr1;
        logic [13:0] sr2;
        logic [13:0] prn;
        logic [4:0]  ovl;
    } ref_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic [3:0]  ch_en;
    logic [15:0] dwell_len;
    logic        ctx_we;
    logic [1:0]  ctx_ch;
    logic [13:0] ctx_sr1, ctx_sr2, ctx_prn;
    logic [4:0]  ctx_ovl;
    logic        gen_do_init;
    logic [13:0] gen_code_state1, gen_code_state2, gen_prn_init;
    logic [4:0]  gen_ovl_init;
    logic        gen_we;
    logic [13:0] gen_sr1, gen_sr2, gen_prn_counter;
    logic [4:0]  gen_ovl_cntr;
    logic        slot_valid;
    logic [1:0]  slot_ch;
    logic        slot_ready;
    logic        slot_done;
    logic        busy;
    logic [1:0]  stat_ch;
    logic [15:0] stat_cnt;

    int   total = 0;
    int   bad   = 0;
    ref_t ref_ctx [4];
    int   stat_m  [4];
    int   last_ch;
    bit   first_m;

    always #5 clk = ~clk;

    facq_prn_sched dut (
        .clk(clk), .reset(reset), .run_en(run_en), .ch_en(ch_en), .dwell_len(dwell_len),
        .ctx_we(ctx_we), .ctx_ch(ctx_ch), .ctx_sr1(ctx_sr1), .ctx_sr2(ctx_sr2),
        .ctx_prn(ctx_prn), .ctx_ovl(ctx_ovl), .gen_do_init(gen_do_init),
        .gen_code_state1(gen_code_state1), .gen_code_state2(gen_code_state2),
        .gen_prn_init(gen_prn_init), .gen_ovl_init(gen_ovl_init), .gen_we(gen_we),
        .gen_sr1(gen_sr1), .gen_sr2(gen_sr2), .gen_prn_counter(gen_prn_counter),
        .gen_ovl_cntr(gen_ovl_cntr), .slot_valid(slot_valid), .slot_ch(slot_ch),
        .slot_ready(slot_ready), .slot_done(slot_done), .busy(busy),
        .stat_ch(stat_ch), .stat_cnt(stat_cnt)
    );

    // One chip of the emulated code generator.
    function automatic ref_t step(input ref_t s);
        ref_t r;
        r.sr1 = {s.sr1[12:0], s.sr1[13] ^ s.sr1[12] ^ s.sr1[10] ^ s.sr1[0]};
        r.sr2 = {s.sr2[12:0], ~(s.sr2[13] ^ s.sr2[5] ^ s.sr2[2])};
        r.prn = s.prn + 14'd1;
        r.ovl = s.ovl + 5'd1;
        return r;
    endfunction

    function automatic ref_t step_n(input ref_t s, input int n);
        ref_t r = s;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    // Next enabled channel after the last served one (channel 0 first after reset).
    function automatic int next_ch(input logic [3:0] m, input int last, input bit first);
        int start = first ? 0 : (last + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            if (m[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // Emulated generator shared by all channels.
    ref_t g = '0;
    always @(posedge clk) begin
        if (gen_do_init)
            g <= '{sr1: gen_code_state1, sr2: gen_code_state2, prn: gen_prn_init, ovl: gen_ovl_init};
        else if (gen_we)
            g <= step(g);
    end
    assign gen_sr1         = g.sr1;
    assign gen_sr2         = g.sr2;
    assign gen_prn_counter = g.prn;
    assign gen_ovl_cntr    = g.ovl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input int ch, input ref_t v);
        @(negedge clk);
        ctx_we  = 1'b1;
        ctx_ch  = 2'(ch);
        ctx_sr1 = v.sr1; ctx_sr2 = v.sr2; ctx_prn = v.prn; ctx_ovl = v.ovl;
        @(negedge clk);
        ctx_we  = 1'b0;
        ref_ctx[ch] = v;
    endtask

    function automatic ref_t rand_ctx();
        ref_t v;
        v.sr1 = 14'($urandom) | 14'd1;
        v.sr2 = 14'($urandom);
        v.prn = 14'($urandom);
        v.ovl = 5'($urandom);
        return v;
    endfunction

    // Follows one slot from load to save; returns at the SAVE-cycle negedge.
    // cpu_at > 0 writes random CPU values to the slot channel on that RUN cycle.
    task automatic serve_slot(input int ready_delay, input int cpu_at);
        int   ch, n, we_cnt, done_cnt, done_at;
        bit   got;
        ref_t cpu;
        ch  = next_ch(ch_en, last_ch, first_m);
        n   = (dwell_len == 16'd0) ? 1 : int'(dwell_len);
        cpu = rand_ctx();
        got = 1'b0;
        if (ready_delay == 0) slot_ready = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = gen_do_init;
        end
        check("load_seen", 32'(got), 32'd1);
        if (!got || ch < 0) return;
        check("slot_ch", 32'(slot_ch), 32'(ch));
        check("ld_sr1", 32'(gen_code_state1), 32'(ref_ctx[ch].sr1));
        check("ld_sr2", 32'(gen_code_state2), 32'(ref_ctx[ch].sr2));
        check("ld_prn", 32'(gen_prn_init), 32'(ref_ctx[ch].prn));
        check("ld_ovl", 32'(gen_ovl_init), 32'(ref_ctx[ch].ovl));
        @(negedge clk);
        check("wait_valid", 32'(slot_valid), 32'd1);
        if (ready_delay > 0) begin
            slot_ready = 1'b0;
            for (int k = 0; k < ready_delay; k++) begin
                check("stall_valid", 32'(slot_valid), 32'd1);
                check("stall_we", 32'(gen_we), 32'd0);
                @(negedge clk);
            end
            slot_ready = 1'b1;
            @(negedge clk);
            check("run_start", 32'(gen_we), 32'd1);
        end else begin
            @(negedge clk);
        end
        we_cnt = 0; done_cnt = 0; done_at = 0;
        for (int k = 0; k < n + 5 && gen_we; k++) begin
            we_cnt++;
            if (slot_done) begin done_cnt++; done_at = we_cnt; end
            if (cpu_at == we_cnt) begin
                ctx_we  = 1'b1;
                ctx_ch  = 2'(ch);
                ctx_sr1 = cpu.sr1; ctx_sr2 = cpu.sr2; ctx_prn = cpu.prn; ctx_ovl = cpu.ovl;
            end
            @(negedge clk);
            ctx_we = 1'b0;
        end
        check("we_cycles", 32'(we_cnt), 32'(n));
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_last", 32'(done_at), 32'(n));
        if (cpu_at > 0) begin
            ref_ctx[ch] = cpu;
        end else begin
            ref_ctx[ch] = step_n(ref_ctx[ch], n);
            if (stat_m[ch] < 65535) stat_m[ch]++;
        end
        last_ch = ch;
        first_m = 1'b0;
    endtask

    task automatic check_stat(input int ch);
        stat_ch = 2'(ch);
        #1;
`ifdef FACQ_SCHED_STAT_EN
        check("stat_cnt", 32'(stat_cnt), 32'(stat_m[ch]));
`else
        check("stat_cnt", 32'(stat_cnt), 32'd0);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ref_ctx[i] = '0;
            stat_m[i]  = 0;
        end
        last_ch = 0;
        first_m = 1'b1;
    endtask

    initial begin
        int   zeros, valids;
        bit   got;
        ref_t v;
        reset = 1'b1; run_en = 1'b0; ch_en = '0; dwell_len = 16'd10;
        ctx_we = 1'b0; ctx_ch = '0; ctx_sr1 = '0; ctx_sr2 = '0; ctx_prn = '0; ctx_ovl = '0;
        slot_ready = 1'b0; stat_ch = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(slot_valid), 32'd0);
        check("rst_we", 32'(gen_we), 32'd0);
        check("rst_init", 32'(gen_do_init), 32'd0);
        check("rst_done", 32'(slot_done), 32'd0);
        check("rst_ch", 32'(slot_ch), 32'd0);
        reset = 1'b0;

        // Preload contexts; channel 2 gets the documented values.
        for (int c = 0; c < 4; c++) begin
            v = rand_ctx();
            if (c == 2) v = '{sr1: 14'h1ABC, sr2: 14'h0123, prn: 14'd5, ovl: 5'd3};
            cpu_write(c, v);
        end
        check_stat(0);

        // Round-robin over channels 0,1,3 with fixed dwell.
        ch_en = 4'b1011; dwell_len = 16'd10; slot_ready = 1'b1; run_en = 1'b1;
        for (int s = 0; s < 6; s++) serve_slot(0, 0);

        // Channel 2 alone: restore, save, stall, CPU override, 1-cycle dwell.
        ch_en = 4'b0100;
        dwell_len = 16'($urandom_range(5, 20));
        serve_slot(0, 0);
        dwell_len = 16'($urandom_range(5, 20));
        serve_slot(0, 0);
        serve_slot(20, 0);
        serve_slot(0, 3);
        serve_slot(0, 0);
        dwell_len = 16'd0;
        serve_slot(0, 0);
        check_stat(2);

        // No channel enabled: the scheduler keeps dropping back to IDLE.
        ch_en = 4'b0000;
        zeros = 0; valids = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!busy) zeros++;
            if (slot_valid) valids++;
        end
        check("idle_cycles", 32'(zeros), 32'd2);
        check("idle_valid", 32'(valids), 32'd0);
        run_en = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of a long dwell.
        ch_en = 4'b0010; dwell_len = 16'd40; run_en = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = gen_we;
        end
        check("long_run_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(gen_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(slot_done), 32'd0);
        check("mid_rst_sr1", 32'(gen_code_state1), 32'd0);
        check("mid_rst_prn", 32'(gen_prn_init), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ch_en = 4'b1111;
        dwell_len = 16'($urandom_range(1, 8));
        serve_slot(0, 0);
        ch_en = 4'b0010;
        for (int s = 0; s < 3; s++) begin
            dwell_len = 16'($urandom_range(1, 8));
            serve_slot(0, 0);
        end
        check_stat(1);
        check_stat(0);
        run_en = 1'b0;
        repeat (4) @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
